// File: rtl/mips32_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips32_pkg
//  Brief    : Shared MIPS32 EX-stage types, default width and funct codes.
//  Revision : 1.0 - initial release
// ============================================================================
package mips32_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mult_state_t;

  // R-type funct codes the EX decode turns into multiplier strobes
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;

endpackage
`default_nettype wire

// File: rtl/ex_mult_hilo_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mult_hilo_if
//  Brief    : EX-stage bus between ID/EX pipeline registers and the HI/LO unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface ex_mult_hilo_if
  import mips32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic             Start_EX;
  logic             Signed_EX;
  logic [WIDTH-1:0] Operand_A_EX;
  logic [WIDTH-1:0] Operand_B_EX;
  logic             Mthi_EX;
  logic             Mtlo_EX;
  logic             Read_HiLo_EX;
  logic             Busy_EX;
  logic             Done_EX;
  logic             Stall_EX;
  logic [WIDTH-1:0] HI_EX;
  logic [WIDTH-1:0] LO_EX;

  modport master (
    output Start_EX, Signed_EX, Operand_A_EX, Operand_B_EX,
    output Mthi_EX, Mtlo_EX, Read_HiLo_EX,
    input  Busy_EX, Done_EX, Stall_EX, HI_EX, LO_EX
  );

  modport slave (
    input  Start_EX, Signed_EX, Operand_A_EX, Operand_B_EX,
    input  Mthi_EX, Mtlo_EX, Read_HiLo_EX,
    output Busy_EX, Done_EX, Stall_EX, HI_EX, LO_EX
  );
endinterface
`default_nettype wire

// File: rtl/ex_mult_hilo.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mult_hilo
//  Brief    : Iterative radix-2 32x32 multiplier with architectural HI/LO.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_mult_hilo
  import mips32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  wire logic     Clk,
  input  wire logic     Reset_n,
  ex_mult_hilo_if.slave ex_bus
);

  localparam int                 c_cnt_w    = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  mult_state_t        r_state;
  mult_state_t        w_next;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_neg;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_busy;
  logic               w_load;
  logic               w_commit;
  logic               w_hilo_wr_ok;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_product;

  // Negating 0x80..0 yields 0x80..0, which is the correct unsigned magnitude
  assign w_mag_a = (ex_bus.Signed_EX && ex_bus.Operand_A_EX[WIDTH-1]) ?
                   -ex_bus.Operand_A_EX : ex_bus.Operand_A_EX;
  assign w_mag_b = (ex_bus.Signed_EX && ex_bus.Operand_B_EX[WIDTH-1]) ?
                   -ex_bus.Operand_B_EX : ex_bus.Operand_B_EX;
  assign w_product = r_neg ? -r_acc : r_acc;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_busy   = 1'b0;
    w_load   = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      IDLE: begin
        if (ex_bus.Start_EX) begin
          w_next = RUN;
          w_load = 1'b1;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (r_cnt == c_cnt_last) begin
          w_next = FIX;
        end
      end
      FIX: begin
        w_busy   = 1'b1;
        w_commit = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Start wins over mthi/mtlo; the decoder never issues both together
  assign w_hilo_wr_ok = (r_state == IDLE) && !ex_bus.Start_EX;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
    end else if (w_load) begin
      r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
      r_mplier <= w_mag_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= ex_bus.Signed_EX &
                  (ex_bus.Operand_A_EX[WIDTH-1] ^ ex_bus.Operand_B_EX[WIDTH-1]);
    end else if (r_state == RUN) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + c_cnt_one;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_commit) begin
        {r_hi, r_lo} <= w_product;
      end else if (w_hilo_wr_ok) begin
        if (ex_bus.Mthi_EX) begin
          r_hi <= ex_bus.Operand_A_EX;
        end
        if (ex_bus.Mtlo_EX) begin
          r_lo <= ex_bus.Operand_A_EX;
        end
      end
    end
  end

  assign ex_bus.Busy_EX  = w_busy;
  assign ex_bus.Done_EX  = r_done;
  assign ex_bus.Stall_EX = w_busy & (ex_bus.Start_EX | ex_bus.Mthi_EX |
                                     ex_bus.Mtlo_EX | ex_bus.Read_HiLo_EX);
  assign ex_bus.HI_EX    = r_hi;
  assign ex_bus.LO_EX    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_ex_mult_hilo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_mult_hilo
//  Brief    : Randomized self-checking bench for ex_mult_hilo.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mult_hilo;

  logic Clk;
  logic Reset_n;
  int   n_total = 0;
  int   n_pass  = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  ex_mult_hilo_if #(.WIDTH(32)) bus ();

  ex_mult_hilo #(.WIDTH(32)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .ex_bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issues a multiply and returns in the Done_EX cycle, so a following call is back-to-back
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input string tag);
    int          k;
    bit          seen;
    bit          stable;
    logic [63:0] p;
    bus.Start_EX     = 1'b1;
    bus.Signed_EX    = sgn;
    bus.Operand_A_EX = a;
    bus.Operand_B_EX = b;
    tick();
    bus.Start_EX     = 1'b0;
    bus.Operand_A_EX = $urandom;
    bus.Operand_B_EX = $urandom;
    check({tag, " busy"}, 64'(bus.Busy_EX), 64'd1);
    k = 0; seen = 0; stable = 1;
    while (!seen && k < 40) begin
      tick();
      k++;
      if (bus.Done_EX) seen = 1;
      else if (bus.HI_EX !== m_hi || bus.LO_EX !== m_lo) stable = 0;
    end
    p = ref_prod(a, b, sgn);
    m_hi = p[63:32];
    m_lo = p[31:0];
    check({tag, " latency"}, 64'(k), 64'd33);
    check({tag, " hold"}, 64'(stable), 64'd1);
    check({tag, " hilo"}, {bus.HI_EX, bus.LO_EX}, {m_hi, m_lo});
    check({tag, " busy_fall"}, 64'(bus.Busy_EX), 64'd0);
  endtask

  initial begin
    int  k;
    bit  stall_ok, hi_ok, done_seen;
    bus.Start_EX = 0; bus.Signed_EX = 0; bus.Operand_A_EX = '0; bus.Operand_B_EX = '0;
    bus.Mthi_EX = 0; bus.Mtlo_EX = 0; bus.Read_HiLo_EX = 0;
    Reset_n = 1'b0;
    repeat (3) tick();
    check("rst hi", 64'(bus.HI_EX), 64'd0);
    check("rst lo", 64'(bus.LO_EX), 64'd0);
    check("rst busy", 64'(bus.Busy_EX), 64'd0);
    check("rst done", 64'(bus.Done_EX), 64'd0);
    check("rst stall", 64'(bus.Stall_EX), 64'd0);
    Reset_n = 1'b1;
    tick();

    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu max");
    tick();
    check("done pulse", 64'(bus.Done_EX), 64'd0);
    do_mult(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, "mult -1x1");
    do_mult(32'h8000_0000, 32'h8000_0000, 1'b1, "mult min^2");
    do_mult(32'h0000_0007, 32'hFFFF_FFFD, 1'b1, "mult 7x-3");
    tick();

    // mthi + mtlo together while idle
    bus.Mthi_EX = 1; bus.Mtlo_EX = 1; bus.Operand_A_EX = 32'h1234_5678;
    #1;
    check("mt stall", 64'(bus.Stall_EX), 64'd0);
    tick();
    bus.Mthi_EX = 0; bus.Mtlo_EX = 0;
    m_hi = 32'h1234_5678; m_lo = 32'h1234_5678;
    check("mt hilo", {bus.HI_EX, bus.LO_EX}, {m_hi, m_lo});

    // mfhi while idle is not stalled and reads committed HI immediately
    bus.Read_HiLo_EX = 1;
    #1;
    check("mf idle stall", 64'(bus.Stall_EX), 64'd0);
    check("mf idle hi", 64'(bus.HI_EX), 64'(m_hi));
    bus.Read_HiLo_EX = 0;

    // mfhi + mthi presented mid-multiply
    bus.Start_EX = 1; bus.Signed_EX = 1;
    bus.Operand_A_EX = 32'h0001_2345; bus.Operand_B_EX = 32'hFFFF_0ABC;
    tick();
    bus.Start_EX = 0;
    k = 0; stall_ok = 1; hi_ok = 1;
    while (bus.Busy_EX && k < 40) begin
      tick();
      k++;
      if (k == 5) begin
        bus.Read_HiLo_EX = 1; bus.Mthi_EX = 1; bus.Operand_A_EX = 32'hDEAD_BEEF;
        #1;
      end
      if (k >= 5 && bus.Busy_EX) begin
        if (bus.Stall_EX !== 1'b1) stall_ok = 0;
        if (bus.HI_EX !== m_hi) hi_ok = 0;
      end
    end
    check("stall held", 64'(stall_ok), 64'd1);
    check("stall hi committed", 64'(hi_ok), 64'd1);
    check("stall release", 64'(bus.Stall_EX), 64'd0);
    check("stall latency", 64'(k), 64'd33);
    check("stall done", 64'(bus.Done_EX), 64'd1);
    bus.Read_HiLo_EX = 0; bus.Mthi_EX = 0;
    {m_hi, m_lo} = ref_prod(32'h0001_2345, 32'hFFFF_0ABC, 1'b1);
    check("stall hilo", {bus.HI_EX, bus.LO_EX}, {m_hi, m_lo});
    tick();

    // Randomized mix of multiplies and HI/LO writes
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.Mthi_EX = 1'($urandom_range(0, 1));
        bus.Mtlo_EX = 1'($urandom_range(0, 1));
        bus.Operand_A_EX = $urandom;
        if (bus.Mthi_EX) m_hi = bus.Operand_A_EX;
        if (bus.Mtlo_EX) m_lo = bus.Operand_A_EX;
        tick();
        bus.Mthi_EX = 0; bus.Mtlo_EX = 0;
        check($sformatf("rnd%0d mt", i), {bus.HI_EX, bus.LO_EX}, {m_hi, m_lo});
      end else begin
        do_mult(pick(), pick(), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        tick();
        check($sformatf("rnd%0d pulse", i), 64'(bus.Done_EX), 64'd0);
      end
    end

    // Reset asserted mid-RUN
    bus.Start_EX = 1; bus.Signed_EX = 0;
    bus.Operand_A_EX = 32'h0001_2345; bus.Operand_B_EX = 32'h0000_6789;
    tick();
    bus.Start_EX = 0;
    repeat (16) tick();
    Reset_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    check("abort hilo", {bus.HI_EX, bus.LO_EX}, 64'd0);
    check("abort busy", 64'(bus.Busy_EX), 64'd0);
    tick();
    Reset_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      tick();
      if (bus.Done_EX) done_seen = 1;
    end
    check("abort no done", 64'(done_seen), 64'd0);
    do_mult(32'd3, 32'd5, 1'b0, "post-rst 3x5");

    // Back-to-back start in the Done_EX cycle
    do_mult(32'hFFFF_FFF9, 32'h0000_0013, 1'b1, "b2b");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_mult_hilo.md
# ex_mult_hilo

Iterative 32×32 multiplier with the architectural HI/LO registers, placed in the EX stage beside the ALU. It is fed from the ID/EX pipeline registers (rs/rt data plus decoded mult/multu/mthi/mtlo/mfhi/mflo strobes). HI/LO are returned to the EX result mux and on into the EX/MEM register. Placing HI/LO here keeps the 64-bit product off the ALU critical path. It raises a stall request while a multiply is in flight.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits
- Clk  in  1  global clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start_EX  in  1  one-cycle request to begin mult/multu
- Signed_EX  in  1  1 = mult (two's complement), 0 = multu; sampled with Start_EX
- Operand_A_EX  in  WIDTH  rs data; multiplicand, or write data for mthi/mtlo
- Operand_B_EX  in  WIDTH  rt data; multiplier
- Mthi_EX  in  1  write HI with Operand_A_EX
- Mtlo_EX  in  1  write LO with Operand_A_EX
- Read_HiLo_EX  in  1  mfhi/mflo present in EX
- Busy_EX  out  1  multiply in progress
- Done_EX  out  1  one-cycle pulse after HI/LO take a product
- Stall_EX  out  1  hold the IF/ID/EX stages this cycle
- HI_EX  out  WIDTH  HI register
- LO_EX  out  WIDTH  LO register

## Operation
- The FSM has three states: IDLE, RUN and FIX.
- IDLE:
  - Start_EX=1: latch |A| and |B| (magnitudes only if Signed_EX, else raw) and neg = Signed_EX & (A[W-1]^B[W-1]). Clear the 2W-bit accumulator and the count, then go to RUN.
  - Otherwise Mthi_EX/Mtlo_EX write HI/LO at the edge. Both may be set together.
- RUN:
  - Radix-2 shift-add, one multiplier bit per cycle, LSB first.
  - The count runs 0..W-1. At W-1 the FSM goes to FIX.
- FIX:
  - Product = neg ? –acc : acc, computed mod 2^(2W).
  - {HI,LO} take the product at the edge leaving FIX. The FSM returns to IDLE.
- Magnitude of the most negative value (0x80000000) is 0x80000000, treated as unsigned. No overflow is possible in 2W bits.
- Start_EX has priority over Mthi/Mtlo in the same cycle. Mthi/Mtlo are then ignored, since the decoder never issues both.
- Start_EX, Mthi_EX and Mtlo_EX are ignored while Busy_EX=1. The stall guarantees the requesting instruction is re-presented.
- Stall_EX = Busy_EX & (Start_EX | Mthi_EX | Mtlo_EX | Read_HiLo_EX). It is combinational.
- HI_EX/LO_EX always show the committed values. They never show partial sums.

## Timing
- Reset (asynchronous assert; release takes effect at the next Clk edge):
  - state=IDLE
  - HI_EX=LO_EX=0
  - Busy_EX=0, Done_EX=0, Stall_EX=0
  - Accumulator and count cleared.
- Start_EX sampled at edge 0 gives this sequence:
  - Busy_EX=1 from after edge 0.
  - RUN spans edges 1..W.
  - FIX is the cycle between edges W and W+1.
  - HI/LO are updated at edge W+1 (33 for W=32).
  - Busy_EX falls at edge W+1. Done_EX=1 for exactly the cycle after edge W+1.
- A back-to-back Start_EX is accepted in the Done_EX cycle (state is IDLE).
- mthi/mtlo latency is 1 edge. mfhi/mflo read HI_EX/LO_EX combinationally, with zero latency, when not stalled.
- Reset mid-RUN/FIX aborts the operation:
  - HI/LO are forced to 0.
  - No Done_EX pulse is produced.

## Structure
- Shared package mips32_pkg holds:
  - mult_state_t enum {IDLE, RUN, FIX}.
  - Default WIDTH.
  - Funct constants FN_MFHI=6'h10, FN_MTHI=6'h11, FN_MFLO=6'h12, FN_MTLO=6'h13, FN_MULT=6'h18, FN_MULTU=6'h19. The EX decode uses these to drive the strobes.
- Single module: FSM, counter and datapath. No sub-module is warranted. The count width is $clog2(WIDTH).

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001, with Done_EX pulsing 33 cycles after Start_EX.
- mult –1 × 1 → HI=LO=0xFFFFFFFF; mult 0x80000000 × 0x80000000 → HI=0x40000000, LO=0; mult 7 × –3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Read_HiLo_EX and Mthi_EX asserted at cycle 5 of a multiply → Stall_EX=1 until Busy_EX falls. HI ends with the product, not the mthi data.
- Mthi_EX=1, Mtlo_EX=1, A=0x12345678 while idle → HI=LO=0x12345678 after 1 edge, Stall_EX=0.
- Reset_n pulsed low mid-RUN (cycle 17) → HI=LO=0 and Busy_EX=0 immediately, no Done_EX. A new Start_EX afterwards completes normally (3 × 5 → LO=15).
- Start_EX in the Done_EX cycle → second product is correct and its Done_EX arrives 33 cycles later.
